shift_and_subtract_binary_divider: RTL and testbench
====================================================

// Module: shift_and_subtract_binary_divider
// PURPOSE
//  Sequential restoring (shift-and-subtract) unsigned binary divider; inverse of our shift-and-add multiplier.
//  Accepts dividend/divisor on a start pulse and produces one quotient bit per clock.
//  Returns quotient, remainder and a div-by-zero flag with a one-cycle done pulse.
//  Sits beside the multiplier in the arithmetic datapath; also used to check multiplier results (C/B == A).
// PARAMETERS
//  N   8   operand width (dividend, divisor, quotient, remainder all N bits)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  start        in   1   request; sampled only while idle (busy=0)
//  dividend     in   N   unsigned dividend, captured on accepted start
//  divisor      in   N   unsigned divisor, captured on accepted start
//  busy         out  1   1 while a division is in progress
//  done         out  1   one-cycle pulse: quotient/remainder/div_by_zero valid
//  quotient     out  N   unsigned quotient, held until the next completion
//  remainder    out  N   unsigned remainder, held until the next completion
//  div_by_zero  out  1   1 if the last completed op had divisor==0; held with results
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal regs cleared.
//  Reset mid-operation aborts immediately; no done pulse; outputs go to reset values.
//  States: IDLE, RUN. All outputs registered.
//  IDLE & start & divisor!=0 (edge E0): capture operands; Q<=dividend, R<=0 (N+1 bits),
//    count<=0, busy<=1, state->RUN.
//  IDLE & start & divisor==0 (edge E0): no RUN; at E0 quotient<={N{1'b1}}, remainder<=dividend,
//    div_by_zero<=1, done<=1 (for one cycle), busy stays 0, state stays IDLE.
//  RUN, each edge: R'={R[N-1:0],Q[N-1]}; Q'={Q[N-2:0],1'b0}; if R'>=divisor_reg then
//    R'=R'-divisor_reg, Q'[0]=1; count<=count+1.
//  On the edge that performs step N (edge E0+N): quotient<=Q', remainder<=R'[N-1:0],
//    div_by_zero<=0, done<=1, busy<=0, state->IDLE.
//  Latency: done is high in the cycle after edge E0+N (exactly N cycles after start accept);
//    divide-by-zero result one cycle after accept.
//  done is a single-cycle pulse; it deasserts on the next edge unless a new div-by-zero op completes.
//  start while busy=1: ignored, operands not recaptured, no effect on the running op.
//  start in the done cycle: accepted (state already IDLE); back-to-back throughput N+1 cycles/op.
//  Operand inputs are not required stable after the accept edge.
//  Invariant for divisor!=0: dividend == quotient*divisor + remainder, remainder < divisor.
//  count is ceil(log2(N+1)) bits wide; no wrap within an op.
// TESTING
//  1) 100/7, start 1 cycle -> busy=1 for 8 cycles, done pulse at cycle 8: q=14, r=2, dbz=0.
//  2) 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 255/255 -> q=1, r=0.
//  3) 42/0 -> done 1 cycle after start, busy never 1: q=255, r=42, dbz=1; next 9/3 -> q=3, r=0, dbz=0.
//  4) 200/3 started, then start with 10/2 at cycle 3 -> ignored; result q=66, r=2.
//  5) Assert rst at cycle 4 of 77/5 -> all outputs 0, no done; then 77/5 -> q=15, r=2.
//  6) Back-to-back: start 17/4 again in its done cycle with 17/4 -> two done pulses 9 cycles
//     apart, both q=4, r=1; random sweep of 1000 ops checks invariant vs reference model.

Source files
------------

// File: rtl/shift_and_subtract_binary_divider.sv
`default_nettype none
// ============================================================================
//  Module   : shift_and_subtract_binary_divider
//  Purpose  : Sequential restoring unsigned divider. Produces one quotient bit
//             per clock. A divisor of zero completes in a single cycle with a
//             flag instead of running the iteration.
//  Ports    : clk, rst        - clock (rising edge), async active-high reset
//             start           - request, sampled only while idle
//             dividend,divisor- N-bit unsigned operands, captured on accept
//             busy            - high while a division is in progress
//             done            - one-cycle pulse when results update
//             quotient,
//             remainder       - N-bit results, held until next completion
//             div_by_zero     - last completed op had divisor == 0
//  Revision : 1.0 - initial release
// ============================================================================
module shift_and_subtract_binary_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;

  logic [N-1:0]  r_q;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_dvsr;
  logic [CW-1:0] r_count;

  logic [N-1:0]  w_q_n;
  logic [N-1:0]  w_rem_n;
  logic [N-1:0]  w_dvsr_n;
  logic [CW-1:0] w_count_n;
  logic          w_busy_n;
  logic          w_done_n;
  logic [N-1:0]  w_quot_n;
  logic [N-1:0]  w_remo_n;
  logic          w_dbz_n;

  logic [N:0]    w_r_shift;
  logic [N:0]    w_r_diff;
  logic          w_ge;
  logic [N-1:0]  w_r_step;
  logic [N-1:0]  w_q_step;
  logic          w_last;
  logic          w_dvsr_zero;

  // One restoring step. The partial remainder is always < divisor between
  // steps, so N bits of storage suffice; only the shifted value needs N+1.
  // When shift < divisor the difference is negative, so its MSB is the
  // borrow and doubles as the compare result.
  always_comb begin
    w_r_shift = {r_rem, r_q[N-1]};
    w_r_diff  = w_r_shift - {1'b0, r_dvsr};
    w_ge      = ~w_r_diff[N];
    w_r_step  = w_ge ? w_r_diff[N-1:0] : w_r_shift[N-1:0];
    w_q_step  = {r_q[N-2:0], w_ge};
    w_last    = (r_count == C_LAST);
    w_dvsr_zero = (divisor == '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !w_dvsr_zero) w_state_next = S_RUN;
      S_RUN:   if (w_last)                w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic; all results are registered below.
  always_comb begin
    w_q_n     = r_q;
    w_rem_n   = r_rem;
    w_dvsr_n  = r_dvsr;
    w_count_n = r_count;
    w_busy_n  = busy;
    w_done_n  = 1'b0;
    w_quot_n  = quotient;
    w_remo_n  = remainder;
    w_dbz_n   = div_by_zero;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_dvsr_zero) begin
            w_q_n     = dividend;
            w_rem_n   = '0;
            w_dvsr_n  = divisor;
            w_count_n = '0;
            w_busy_n  = 1'b1;
          end else begin
            // Divide-by-zero completes immediately without iterating.
            w_quot_n = {N{1'b1}};
            w_remo_n = dividend;
            w_dbz_n  = 1'b1;
            w_done_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_q_n     = w_q_step;
        w_rem_n   = w_r_step;
        w_count_n = r_count + 1'b1;
        if (w_last) begin
          w_quot_n = w_q_step;
          w_remo_n = w_r_step;
          w_dbz_n  = 1'b0;
          w_done_n = 1'b1;
          w_busy_n = 1'b0;
        end
      end
      default: w_busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      r_rem       <= '0;
      r_dvsr      <= '0;
      r_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_q         <= w_q_n;
      r_rem       <= w_rem_n;
      r_dvsr      <= w_dvsr_n;
      r_count     <= w_count_n;
      busy        <= w_busy_n;
      done        <= w_done_n;
      quotient    <= w_quot_n;
      remainder   <= w_remo_n;
      div_by_zero <= w_dbz_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_and_subtract_binary_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_and_subtract_binary_divider
//  Purpose  : Directed checks of the shift-and-subtract divider plus a
//             random sweep against a reference division model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_and_subtract_binary_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_and_subtract_binary_divider #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; returns #1 after the accept edge, then
  // scrambles the operand inputs since they need not stay stable.
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a[7:0];
    divisor  = b[7:0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Counts edges until done is seen (0 if already high) and busy cycles.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && busy) bcnt++;
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL timeout observed=%0d expected=%0d", cyc, 8);
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input int eq, input int er, input int edbz, input int elat);
    int cyc, bcnt;
    start_op(a, b);
    wait_done(cyc, bcnt);
    chk({tag, "_lat"}, cyc, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int cyc, bcnt, gap, seen;
    int a, b, eq, er, edbz;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 : busy for 8 cycles, done 8 cycles after accept
    start_op(100, 7);
    chk("t1_busy_accept", busy, 1);
    wait_done(cyc, bcnt);
    chk("t1_lat", cyc, 8);
    chk("t1_busy_cycles", bcnt, 8);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_q", quotient, 14);
    chk("t1_r", remainder, 2);
    chk("t1_dbz", div_by_zero, 0);
    @(posedge clk);
    #1;
    chk("t1_pulse", done, 0);
    chk("t1_hold_q", quotient, 14);

    run_op("t2a", 255, 1, 255, 0, 0, 8);
    run_op("t2b", 5, 9, 0, 5, 0, 8);
    run_op("t2c", 255, 255, 1, 0, 0, 8);

    // 42 / 0 : immediate, busy never set
    start_op(42, 0);
    chk("t3_busy", busy, 0);
    wait_done(cyc, bcnt);
    chk("t3_lat", cyc, 0);
    chk("t3_busy_cycles", bcnt, 0);
    chk("t3_q", quotient, 255);
    chk("t3_r", remainder, 42);
    chk("t3_dbz", div_by_zero, 1);
    @(posedge clk);
    #1;
    chk("t3_pulse", done, 0);
    chk("t3_hold_dbz", div_by_zero, 1);
    run_op("t3b", 9, 3, 3, 0, 0, 8);

    // 200 / 3 with an ignored start (10 / 2) at cycle 3
    start_op(200, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd10; divisor = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("t4_lat", cyc, 5);
    chk("t4_q", quotient, 66);
    chk("t4_r", remainder, 2);

    // Reset in the middle of 77 / 5
    start_op(77, 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_q", quotient, 0);
    chk("t5_r", remainder, 0);
    chk("t5_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("t5_no_done", seen, 0);
    run_op("t5b", 77, 5, 15, 2, 0, 8);

    // Back-to-back 17 / 4, second start in the done cycle
    start_op(17, 4);
    wait_done(cyc, bcnt);
    chk("t6a_q", quotient, 4);
    chk("t6a_r", remainder, 1);
    start = 1'b1; dividend = 8'd17; divisor = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t6_busy_accept", busy, 1);
    gap = 1;
    wait_done(cyc, bcnt);
    gap += cyc;
    chk("t6_gap", gap, 9);
    chk("t6b_q", quotient, 4);
    chk("t6b_r", remainder, 1);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 50 == 0) ? 0 : $urandom_range(0, 255);
      if (b == 0) begin
        eq = 255; er = a; edbz = 1;
      end else begin
        eq = a / b; er = a % b; edbz = 0;
      end
      start_op(a, b);
      wait_done(cyc, bcnt);
      chk("rnd_q", quotient, eq);
      chk("rnd_r", remainder, er);
      chk("rnd_dbz", div_by_zero, edbz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
